// File: rtl/pll_reset_seq.sv
// pll_reset_seq: brings the reference-clock PLL from power-up to a debounced,
// locked running state. It drives the PLL reset, qualifies the synchronised lock
// flag, retries on timeout, and holds the core reset until the clocks are stable.
// Loss of lock or an explicit relock request starts the sequence again.
module pll_reset_seq #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  // The single cycle counter has to reach the largest terminal count.
  localparam int MAX_A = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, core_reset_q, ready_q, fail_q;
  logic             pll_rst_d, core_reset_d, ready_d, fail_d;

  // Two-flop synchroniser bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  // Next-state, counter and output decode; outputs follow the next state so
  // they change on the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    lol_d   = lol_q;

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_LIMIT) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABLE: begin
        // A lock glitch restarts the wait but is not counted as a retry.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = 3'd0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          lol_d   = (lol_q == 8'hFF) ? lol_q : lol_q + 8'd1;
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Relock overrides every other transition; a loss of lock counted above
    // in the same cycle is kept.
    if (relock_req) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = 3'd0;
    end

    pll_rst_d    = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    core_reset_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
    fail_d       = (state_d == S_FAIL);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= 3'd0;
      lol_q        <= 8'd0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lol_q        <= lol_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;
  assign lol_cnt    = lol_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed testbench for pll_reset_seq with RST_PULSE=4, LOCK_TIMEOUT=20,
// LOCK_STABLE=8, MAX_RETRY=2. Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] lol_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  pll_reset_seq #(
    .RST_PULSE(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRY(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lol_cnt(lol_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    step(3);
    vec_cnt++;
    if ({pll_rst, core_reset, ready, fail} !== 4'b1100) begin
      $display("FAIL reset_flags: got %b expected 1100", {pll_rst, core_reset, ready, fail}); err_cnt++;
    end
    vec_cnt++;
    if (retry_cnt !== 3'd0 || lol_cnt !== 8'd0) begin
      $display("FAIL reset_counts: got retry=%0d lol=%0d expected 0 0", retry_cnt, lol_cnt); err_cnt++;
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_start();
    int n;
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin
      step(1);
      n++;
    end
    vec_cnt++;
    if (n !== 4) begin
      $display("FAIL clean_pulse_len: got %0d expected 4", n); err_cnt++;
    end
    step(5);
    pll_locked = 1'b1;
    step(10);
    vec_cnt++;
    if (ready !== 1'b0 || core_reset !== 1'b1) begin
      $display("FAIL clean_early_ready: got ready=%b core_reset=%b expected 0 1", ready, core_reset); err_cnt++;
    end
    step(1);
    vec_cnt++;
    if (ready !== 1'b1 || core_reset !== 1'b0 || pll_rst !== 1'b0) begin
      $display("FAIL clean_ready: got ready=%b core_reset=%b pll_rst=%b expected 1 0 0", ready, core_reset, pll_rst); err_cnt++;
    end
    vec_cnt++;
    if (retry_cnt !== 3'd0) begin
      $display("FAIL clean_retry: got %0d expected 0", retry_cnt); err_cnt++;
    end
    $display("test_clean_start done");
  endtask

  task automatic test_loss_of_lock();
    int n;
    int exp_lol;
    for (int i = 1; i <= 300; i++) begin
      exp_lol = (i < 255) ? i : 255;
      pll_locked = 1'b0;
      step(2);
      if (i == 1) begin
        vec_cnt++;
        if (core_reset !== 1'b0 || pll_rst !== 1'b0) begin
          $display("FAIL lol_too_early: got core_reset=%b pll_rst=%b expected 0 0", core_reset, pll_rst); err_cnt++;
        end
      end
      step(1);
      vec_cnt++;
      if (core_reset !== 1'b1 || pll_rst !== 1'b1 || ready !== 1'b0) begin
        $display("FAIL lol_react[%0d]: got core_reset=%b pll_rst=%b ready=%b expected 1 1 0", i, core_reset, pll_rst, ready); err_cnt++;
      end
      vec_cnt++;
      if (lol_cnt !== 8'(exp_lol)) begin
        $display("FAIL lol_count[%0d]: got %0d expected %0d", i, lol_cnt, exp_lol); err_cnt++;
      end
      pll_locked = 1'b1;
      if (i == 1) begin
        step(3);
        vec_cnt++;
        if (pll_rst !== 1'b1) begin
          $display("FAIL lol_pulse_hold: got %b expected 1", pll_rst); err_cnt++;
        end
        step(1);
        vec_cnt++;
        if (pll_rst !== 1'b0) begin
          $display("FAIL lol_pulse_end: got %b expected 0", pll_rst); err_cnt++;
        end
      end
      n = 0;
      while (!ready && n < 40) begin
        step(1);
        n++;
      end
      vec_cnt++;
      if (ready !== 1'b1) begin
        $display("FAIL lol_resequence[%0d]: got ready=%b expected 1", i, ready); err_cnt++;
      end
    end
    $display("test_loss_of_lock done lol_cnt=%0d", lol_cnt);
  endtask

  task automatic test_reset_mid_stable();
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    step(6);
    vec_cnt++;
    if (ready !== 1'b0 || core_reset !== 1'b1 || pll_rst !== 1'b0 || lol_cnt !== 8'd255) begin
      $display("FAIL mid_stable_pre: got ready=%b core_reset=%b pll_rst=%b lol=%0d expected 0 1 0 255", ready, core_reset, pll_rst, lol_cnt); err_cnt++;
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    vec_cnt++;
    if ({pll_rst, core_reset, ready, fail} !== 4'b1100 || retry_cnt !== 3'd0 || lol_cnt !== 8'd0) begin
      $display("FAIL mid_stable_reset: got flags=%b retry=%0d lol=%0d expected 1100 0 0", {pll_rst, core_reset, ready, fail}, retry_cnt, lol_cnt); err_cnt++;
    end
    step(3);
    vec_cnt++;
    if (pll_rst !== 1'b1) begin
      $display("FAIL mid_stable_pulse_hold: got %b expected 1", pll_rst); err_cnt++;
    end
    step(1);
    vec_cnt++;
    if (pll_rst !== 1'b0) begin
      $display("FAIL mid_stable_pulse_end: got %b expected 0", pll_rst); err_cnt++;
    end
    $display("test_reset_mid_stable done");
  endtask

  task automatic test_never_locks();
    logic       exp_rst;
    logic       exp_fail;
    logic [2:0] exp_retry;
    pll_locked = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      step(1);
      exp_rst   = (c < 4) || (c >= 24 && c < 28) || (c >= 48 && c < 52) || (c >= 72);
      exp_fail  = (c >= 72);
      exp_retry = (c >= 48) ? 3'd2 : ((c >= 24) ? 3'd1 : 3'd0);
      vec_cnt++;
      if (pll_rst !== exp_rst || fail !== exp_fail || retry_cnt !== exp_retry) begin
        $display("FAIL never_locks[c=%0d]: got pll_rst=%b fail=%b retry=%0d expected %b %b %0d", c, pll_rst, fail, retry_cnt, exp_rst, exp_fail, exp_retry); err_cnt++;
      end
    end
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    vec_cnt++;
    if (fail !== 1'b0 || retry_cnt !== 3'd0 || pll_rst !== 1'b1 || core_reset !== 1'b1) begin
      $display("FAIL relock_from_fail: got fail=%b retry=%0d pll_rst=%b core_reset=%b expected 0 0 1 1", fail, retry_cnt, pll_rst, core_reset); err_cnt++;
    end
    step(3);
    vec_cnt++;
    if (pll_rst !== 1'b1) begin
      $display("FAIL relock_fail_pulse_hold: got %b expected 1", pll_rst); err_cnt++;
    end
    step(1);
    vec_cnt++;
    if (pll_rst !== 1'b0) begin
      $display("FAIL relock_fail_pulse_end: got %b expected 0", pll_rst); err_cnt++;
    end
    $display("test_never_locks done");
  endtask

  task automatic test_lock_glitch();
    pll_locked = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(30);
    vec_cnt++;
    if (retry_cnt !== 3'd1 || pll_rst !== 1'b0) begin
      $display("FAIL glitch_setup: got retry=%0d pll_rst=%b expected 1 0", retry_cnt, pll_rst); err_cnt++;
    end
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    for (int c = 37; c <= 46; c++) begin
      step(1);
      vec_cnt++;
      if (ready !== 1'b0 || core_reset !== 1'b1 || pll_rst !== 1'b0 || retry_cnt !== 3'd1) begin
        $display("FAIL glitch_hold[c=%0d]: got ready=%b core_reset=%b pll_rst=%b retry=%0d expected 0 1 0 1", c, ready, core_reset, pll_rst, retry_cnt); err_cnt++;
      end
    end
    step(1);
    vec_cnt++;
    if (ready !== 1'b1 || core_reset !== 1'b0 || retry_cnt !== 3'd0) begin
      $display("FAIL glitch_release: got ready=%b core_reset=%b retry=%0d expected 1 0 0", ready, core_reset, retry_cnt); err_cnt++;
    end
    $display("test_lock_glitch done");
  endtask

  task automatic test_relock();
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    vec_cnt++;
    if (pll_rst !== 1'b1 || ready !== 1'b0 || core_reset !== 1'b1 || retry_cnt !== 3'd0 || lol_cnt !== 8'd0) begin
      $display("FAIL relock_run: got pll_rst=%b ready=%b core_reset=%b retry=%0d lol=%0d expected 1 0 1 0 0", pll_rst, ready, core_reset, retry_cnt, lol_cnt); err_cnt++;
    end
    step(12);
    vec_cnt++;
    if (ready !== 1'b0) begin
      $display("FAIL relock_run_early: got ready=%b expected 0", ready); err_cnt++;
    end
    step(1);
    vec_cnt++;
    if (ready !== 1'b1) begin
      $display("FAIL relock_run_recover: got ready=%b expected 1", ready); err_cnt++;
    end
    pll_locked = 1'b0;
    step(2);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    vec_cnt++;
    if (pll_rst !== 1'b1 || ready !== 1'b0 || lol_cnt !== 8'd1) begin
      $display("FAIL relock_coincident: got pll_rst=%b ready=%b lol=%0d expected 1 0 1", pll_rst, ready, lol_cnt); err_cnt++;
    end
    step(2);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    step(3);
    vec_cnt++;
    if (pll_rst !== 1'b1 || lol_cnt !== 8'd1) begin
      $display("FAIL relock_restart_hold: got pll_rst=%b lol=%0d expected 1 1", pll_rst, lol_cnt); err_cnt++;
    end
    step(1);
    vec_cnt++;
    if (pll_rst !== 1'b0 || lol_cnt !== 8'd1) begin
      $display("FAIL relock_restart_end: got pll_rst=%b lol=%0d expected 0 1", pll_rst, lol_cnt); err_cnt++;
    end
    $display("test_relock done");
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    test_reset();
    test_clean_start();
    test_loss_of_lock();
    test_reset_mid_stable();
    test_never_locks();
    test_lock_glitch();
    test_relock();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Sequences the 50 MHz-referenced video/system PLL from power-up to a clean, debounced running state. It drives the PLL's reset, synchronises and qualifies its `locked` flag, retries lock on timeout, and holds the downstream core reset until the generated clocks are stable. It sits between the top-level reset and the PLL instance, in the reference-clock domain. It also re-sequences the PLL on loss of lock or on an explicit relock request, for example after a video-mode change.

## Interface
Parameters:
- `RST_PULSE`, 16: cycles the PLL reset is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock before retrying (≥2).
- `LOCK_STABLE`, 1024: cycles the synchronised lock must stay continuously high before release (≥1).
- `MAX_RETRY`, 7: retries allowed after the first attempt before declaring failure (0–7).

Ports:
- `refclk` in 1: the single clock, 50 MHz reference.
- `rst` in 1: reset, synchronous, active-high.
- `pll_locked` in 1: raw PLL lock flag, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle pulse that forces a new PLL reset sequence.
- `pll_rst` out 1: PLL reset.
- `core_reset` out 1: downstream core reset, active-high.
- `ready` out 1: PLL is locked and stable, and `core_reset` is released.
- `fail` out 1: retries are exhausted.
- `retry_cnt` out 3: attempts retried in the current sequence.
- `lol_cnt` out 8: loss-of-lock events seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lock_s`. All decisions use `lock_s`.
- One internal counter `cnt` is sized to the largest parameter. It clears on every state entry.
- All outputs are registered and take their new value on the same edge the state changes.
- States and transitions:
  - **RESET_PLL**: `pll_rst`=1, `core_reset`=1, `ready`=0.
    - When `cnt`==RST_PULSE-1, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0, `core_reset`=1.
    - If `lock_s`=1, go to STABLE.
    - Else, when `cnt`==LOCK_TIMEOUT-1: if `retry_cnt`==MAX_RETRY, go to FAIL; otherwise increment `retry_cnt` and go to RESET_PLL.
  - **STABLE**: `pll_rst`=0, `core_reset`=1.
    - If `lock_s`=0, return to WAIT_LOCK. This is a glitch: the timeout restarts and `retry_cnt` is unchanged.
    - When `cnt`==LOCK_STABLE-1 with `lock_s`=1, go to RUN.
  - **RUN**: `core_reset`=0, `ready`=1. Entering RUN clears `retry_cnt`.
    - If `lock_s`=0, increment `lol_cnt` (saturating) and go to RESET_PLL.
  - **FAIL**: `pll_rst`=1, `core_reset`=1, `fail`=1. Held until `rst` or `relock_req`.
- `relock_req` in any state clears `retry_cnt` and `fail` and goes to RESET_PLL.
  - It has priority over every other transition.
  - In RUN, a simultaneous `lock_s` drop still increments `lol_cnt`.
- `relock_req` arriving while already in RESET_PLL restarts the pulse (`cnt` clears).
- `lol_cnt` clears only on `rst`.

## Timing
- Reset values while `rst`=1, and on the first edge after it: state RESET_PLL, `pll_rst`=1, `core_reset`=1, `ready`=0, `fail`=0, `retry_cnt`=0, `lol_cnt`=0, `cnt`=0, synchroniser=0.
- `pll_rst` is high for exactly RST_PULSE cycles per attempt, counted from the first edge with `rst` low.
- A `pll_locked` rise becomes visible in `lock_s` 2 cycles later.
- Release latency:
  - `ready` and `core_reset` deassert LOCK_STABLE cycles after the STABLE state is entered.
  - STABLE is entered 1 cycle after `lock_s` rises.
- Loss of lock in RUN: `core_reset` reasserts and `pll_rst` rises on the edge after `lock_s` falls, i.e. 3 cycles after the `pll_locked` fall.
- Worst-case time to FAIL: (MAX_RETRY+1)·(RST_PULSE+LOCK_TIMEOUT) cycles after reset.
- `rst` asserted mid-sequence in any state returns all outputs to their reset values on that edge. `lol_cnt` is cleared.

## Test plan
All scenarios use RST_PULSE=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
- **Clean start**: raise `pll_locked` 5 cycles after `pll_rst` falls -> `pll_rst` is high for 4 cycles; `ready`=1 and `core_reset`=0 exactly 2+1+8 cycles after the `pll_locked` rise; `retry_cnt`=0.
- **Never locks**: hold `pll_locked`=0 -> 3 `pll_rst` pulses, each 4 cycles, spaced 20 cycles apart; `retry_cnt` steps 1, 2; `fail`=1 at cycle 72; `pll_rst` stays high afterwards.
- **Lock glitch**: drop `pll_locked` for 1 cycle during STABLE -> back to WAIT_LOCK with no retry increment; `ready` only after a fresh 8-cycle stable window.
- **Loss of lock in RUN**: drop `pll_locked` -> `core_reset`=1 and `pll_rst`=1 three cycles later; `lol_cnt`=1; the full sequence runs again. Repeat 300 times -> `lol_cnt` holds at 255.
- **Relock and recover**: pulse `relock_req` in FAIL and in RUN -> `fail`=0, `retry_cnt`=0, RESET_PLL entered the next cycle. The same pulse coincident with a `lock_s` drop in RUN -> single RESET_PLL entry, `lol_cnt`+1.
- **Reset mid-STABLE**: assert `rst` for 1 cycle -> all outputs at reset values, and the 4-cycle `pll_rst` pulse restarts.
